// File: rtl/rv64g_reg_scoreboard_pkg.sv
// Shared register-file constants and scoreboard state type for the RV64G core.
package rv64g_pkg;

   localparam int NUM_REGS     = 64;
   localparam int NUM_WB_PORTS = 2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sb_state_e;

endpackage : rv64g_pkg

// File: rtl/rv64g_reg_scoreboard_count_ones.sv
// Combinational population count of an NW-bit vector.
module count_ones #(
   parameter  int NW = 64,
   localparam int CW = $clog2(NW + 1)
) (
   input  logic [NW-1:0] bits,
   output logic [CW-1:0] count
);

   // ripple sum of all set bits
   always_comb begin
      count = {CW{1'b0}};
      for (int i = 0; i < NW; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule : count_ones

// File: rtl/rv64g_reg_scoreboard.sv
// Per-register write-pending scoreboard with flush/drain controller.
// Protocol checking is compiled in with RV64G_SCOREBOARD_CHECK_EN.
module rv64g_reg_scoreboard
   import rv64g_pkg::*;
#(
   parameter  int NR  = NUM_REGS,
   parameter  int NWB = NUM_WB_PORTS,
   localparam int RW  = $clog2(NR),
   localparam int CW  = $clog2(NR + 1)
) (
   input  logic                    arst_ni,
   input  logic                    clk_i,
   input  logic                    clear_i,
   input  logic                    issue_valid_i,
   input  logic                    issue_ready_i,
   input  logic [RW-1:0]           issue_rd_i,
   input  logic                    issue_wr_i,
   input  logic [NWB-1:0]          wb_valid_i,
   input  logic [NWB-1:0][RW-1:0]  wb_rd_i,
   input  logic                    flush_req_i,
   output logic                    issue_allow_o,
   output logic                    flush_ack_o,
   output logic [NR-1:0]           locks_o,
   output logic [CW-1:0]           outstanding_o,
   output logic                    err_o
);

   logic            issue_fire_s;
   logic            locks_zero_s;
   logic [NR-1:0]   set_mask_s;
   logic [NR-1:0]   clr_mask_s;
   logic [NR-1:0]   locks_nxt_s;
   logic [NR-1:0]   locks_r;
   sb_state_e       state_r;
   sb_state_e       state_nxt_s;

   assign issue_fire_s = issue_valid_i & issue_ready_i;
   assign locks_zero_s = (locks_r == {NR{1'b0}});

   // Set/clear masks; bit 0 (x0) never participates, so it is never locked
   always_comb begin
      set_mask_s = {NR{1'b0}};
      clr_mask_s = {NR{1'b0}};
      for (int i = 1; i < NR; i++) begin
         set_mask_s[i] = issue_fire_s & issue_wr_i & (issue_rd_i == RW'(i));
         for (int p = 0; p < NWB; p++) begin
            clr_mask_s[i] = clr_mask_s[i] | (wb_valid_i[p] & (wb_rd_i[p] == RW'(i)));
         end
      end
      locks_nxt_s = (locks_r & ~clr_mask_s) | set_mask_s;
   end

   // Lock register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         locks_r <= {NR{1'b0}};
      end else if (clear_i) begin
         locks_r <= {NR{1'b0}};
      end else begin
         locks_r <= locks_nxt_s;
      end
   end

   // Flush controller next-state; a late fire in DRAIN postpones DONE by a cycle
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (flush_req_i) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (!flush_req_i) begin
               state_nxt_s = RUN;
            end else if (locks_zero_s && !issue_fire_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE: begin
            if (!flush_req_i) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = RUN;
      endcase
   end

   // Flush controller state register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_r <= RUN;
      end else if (clear_i) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   assign issue_allow_o = (state_r == RUN);
   assign flush_ack_o   = (state_r == DONE);
   assign locks_o       = locks_r;

   count_ones #(.NW(NR)) u_count_ones (
      .bits  (locks_r),
      .count (outstanding_o)
   );

`ifdef RV64G_SCOREBOARD_CHECK_EN
   logic err_evt_s;
   logic err_r;

   // Protocol violations: gated issue, double-lock, retire of an idle register
   always_comb begin
      err_evt_s = (issue_fire_s & ~issue_allow_o)
                | (|(set_mask_s & locks_r & ~clr_mask_s))
                | (|(clr_mask_s & ~locks_r & ~set_mask_s));
   end

   // Sticky error flag
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         err_r <= 1'b0;
      end else if (clear_i) begin
         err_r <= 1'b0;
      end else if (err_evt_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err_o = err_r;
`else
   assign err_o = 1'b0;
`endif

endmodule : rv64g_reg_scoreboard

// File: tb/tb_rv64g_reg_scoreboard.sv
// Directed plus randomized bench for rv64g_reg_scoreboard against a behavioural model.
module tb_rv64g_reg_scoreboard;

   localparam int NR  = rv64g_pkg::NUM_REGS;
   localparam int NWB = rv64g_pkg::NUM_WB_PORTS;
   localparam int RW  = $clog2(NR);
   localparam int CW  = $clog2(NR + 1);
`ifdef RV64G_SCOREBOARD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic                   arst_ni = 1'b0;
   logic                   clk_i = 1'b0;
   logic                   clear_i;
   logic                   issue_valid_i;
   logic                   issue_ready_i;
   logic [RW-1:0]          issue_rd_i;
   logic                   issue_wr_i;
   logic [NWB-1:0]         wb_valid_i;
   logic [NWB-1:0][RW-1:0] wb_rd_i;
   logic                   flush_req_i;
   logic                   issue_allow_o;
   logic                   flush_ack_o;
   logic [NR-1:0]          locks_o;
   logic [CW-1:0]          outstanding_o;
   logic                   err_o;

   int checks = 0;
   int errors = 0;

   // Model: one flag per register, a mode (0 running, 1 draining, 2 drained), sticky error
   bit m_lock[NR];
   int m_mode;
   bit m_err;

   rv64g_reg_scoreboard dut (
      .arst_ni       (arst_ni),
      .clk_i         (clk_i),
      .clear_i       (clear_i),
      .issue_valid_i (issue_valid_i),
      .issue_ready_i (issue_ready_i),
      .issue_rd_i    (issue_rd_i),
      .issue_wr_i    (issue_wr_i),
      .wb_valid_i    (wb_valid_i),
      .wb_rd_i       (wb_rd_i),
      .flush_req_i   (flush_req_i),
      .issue_allow_o (issue_allow_o),
      .flush_ack_o   (flush_ack_o),
      .locks_o       (locks_o),
      .outstanding_o (outstanding_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [NR-1:0] m_vec();
      logic [NR-1:0] v = '0;
      for (int i = 0; i < NR; i++) v[i] = m_lock[i];
      return v;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(m_lock[i]);
      return n;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NR; i++) m_lock[i] = 1'b0;
      m_mode = 0;
      m_err  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".locks"}, 64'(locks_o), 64'(m_vec()));
      chk({tag, ".outstanding"}, 64'(outstanding_o), 64'(m_count()));
      chk({tag, ".allow"}, 64'(issue_allow_o), 64'(m_mode == 0));
      chk({tag, ".ack"}, 64'(flush_ack_o), 64'(m_mode == 2));
      chk({tag, ".err"}, 64'(err_o), 64'(m_err));
   endtask

   task automatic idle();
      clear_i       = 1'b0;
      issue_valid_i = 1'b0;
      issue_ready_i = 1'b0;
      issue_rd_i    = '0;
      issue_wr_i    = 1'b0;
      wb_valid_i    = '0;
      wb_rd_i       = '0;
   endtask

   task automatic issue(input int rd);
      issue_valid_i = 1'b1;
      issue_ready_i = 1'b1;
      issue_wr_i    = 1'b1;
      issue_rd_i    = RW'(rd);
   endtask

   task automatic wb(input int p, input int rd);
      wb_valid_i[p] = 1'b1;
      wb_rd_i[p]    = RW'(rd);
   endtask

   // Predict the next cycle from the current inputs, clock once, compare, then clear inputs
   task automatic step(input string tag);
      bit nl[NR];
      bit ne;
      int nm;
      bit fire;
      bit cleared;
      bit empty;
      fire  = issue_valid_i && issue_ready_i;
      empty = (m_count() == 0);
      nl    = m_lock;
      ne    = m_err;
      nm    = m_mode;
      cleared = 1'b0;
      for (int p = 0; p < NWB; p++) begin
         if (wb_valid_i[p] && wb_rd_i[p] != 0) begin
            nl[wb_rd_i[p]] = 1'b0;
            if (wb_rd_i[p] == issue_rd_i) cleared = 1'b1;
            if (CHK && !m_lock[wb_rd_i[p]] &&
                !(fire && issue_wr_i && issue_rd_i == wb_rd_i[p])) ne = 1'b1;
         end
      end
      if (fire && issue_wr_i && issue_rd_i != 0) begin
         nl[issue_rd_i] = 1'b1;
         if (CHK && m_lock[issue_rd_i] && !cleared) ne = 1'b1;
      end
      if (CHK && fire && m_mode != 0) ne = 1'b1;
      if (m_mode == 0)      nm = flush_req_i ? 1 : 0;
      else if (m_mode == 1) nm = !flush_req_i ? 0 : ((empty && !fire) ? 2 : 1);
      else                  nm = flush_req_i ? 2 : 0;
      if (clear_i) begin
         for (int i = 0; i < NR; i++) nl[i] = 1'b0;
         ne = 1'b0;
         nm = 0;
      end
      @(posedge clk_i);
      #1;
      m_lock = nl;
      m_err  = ne;
      m_mode = nm;
      check_all(tag);
      idle();
   endtask

   initial begin
      idle();
      flush_req_i = 1'b0;
      m_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_all("reset");
      chk("reset.allow_const", 64'(issue_allow_o), 64'd1);
      arst_ni = 1'b1;

      // basic set then clear
      issue(5);      step("set5");
      chk("set5.locks", 64'(locks_o), 64'h20);
      chk("set5.cnt", 64'(outstanding_o), 64'd1);
      wb(0, 5);      step("clr5");
      chk("clr5.locks", 64'(locks_o), 64'h0);

      // x0 is ignored everywhere
      issue(0); wb(1, 0); step("x0");
      chk("x0.locks", 64'(locks_o), 64'h0);
      chk("x0.err", 64'(err_o), 64'd0);

      // same-cycle set/clear and dual-port clear
      issue(7); step("set7");
      issue(3); step("set3");
      issue(9); step("set9");
      issue(7); wb(0, 7); step("setclr7");
      chk("setclr7.bit", 64'(locks_o[7]), 64'd1);
      chk("setclr7.err", 64'(err_o), 64'd0);
      wb(0, 3); wb(1, 9); step("dual");
      chk("dual.locks", 64'(locks_o), 64'h80);
      wb(0, 7); step("clr7");

      // drain with three outstanding writes
      issue(2); step("set2");
      issue(4); step("set4");
      issue(6); step("set6");
      flush_req_i = 1'b1; step("flush_req");
      chk("flush.allow", 64'(issue_allow_o), 64'd0);
      step("drain_gap");
      wb(0, 2); step("ret2");
      wb(0, 4); step("ret4");
      wb(1, 6); step("ret6");
      chk("drain.ack_early", 64'(flush_ack_o), 64'd0);
      step("drain_done");
      chk("drain.ack", 64'(flush_ack_o), 64'd1);
      flush_req_i = 1'b0; step("release");
      chk("release.allow", 64'(issue_allow_o), 64'd1);

      // minimum flush latency
      flush_req_i = 1'b1; step("minflush1");
      chk("minflush1.ack", 64'(flush_ack_o), 64'd0);
      step("minflush2");
      chk("minflush2.ack", 64'(flush_ack_o), 64'd1);
      flush_req_i = 1'b0; step("minflush3");

      // retire of an unlocked register
      wb(0, 12); step("wb_unlocked");
      chk("wb_unlocked.err", 64'(err_o), 64'(CHK));
      step("err_hold");
      chk("err_hold.err", 64'(err_o), 64'(CHK));
      clear_i = 1'b1; step("clear");
      chk("clear.err", 64'(err_o), 64'd0);

      // asynchronous reset while draining
      for (int r = 1; r <= 4; r++) begin
         issue(r); step("pre_rst");
      end
      flush_req_i = 1'b1; step("drain_rst");
      #2;
      arst_ni = 1'b0;
      #1;
      m_reset();
      chk("arst.locks", 64'(locks_o), 64'h0);
      chk("arst.allow", 64'(issue_allow_o), 64'd1);
      check_all("arst");
      flush_req_i = 1'b0;
      @(posedge clk_i);
      #1;
      arst_ni = 1'b1;
      issue(11); step("post_rst");
      chk("post_rst.locks", 64'(locks_o), 64'h800);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         issue_valid_i = 1'($urandom_range(0, 1));
         issue_ready_i = 1'($urandom_range(0, 3) != 0);
         issue_wr_i    = 1'($urandom_range(0, 3) != 0);
         issue_rd_i    = RW'($urandom_range(0, 15));
         for (int p = 0; p < NWB; p++) begin
            wb_valid_i[p] = 1'($urandom_range(0, 1));
            wb_rd_i[p]    = RW'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) flush_req_i = ~flush_req_i;
         clear_i = 1'($urandom_range(0, 39) == 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rv64g_reg_scoreboard

// File: doc/rv64g_reg_scoreboard.md
# rv64g_reg_scoreboard

Tracks which architectural registers have an in-flight write and drives the per-register lock vector consumed by the instruction launcher's hazard checkers. Sets a register's lock when an instruction that writes it is issued, and clears the lock when a writeback port retires that register. Contains a flush/drain controller that stops issue, waits for all outstanding writes to retire, then acknowledges. Sits between the launcher output handshake and the writeback buses of the execution units.

## Interface
- NR, rv64g_pkg::NUM_REGS (64): number of tracked registers; index 0 is x0 and is never locked.
- NWB, rv64g_pkg::NUM_WB_PORTS (2): number of writeback ports.
- arst_ni  input  1  asynchronous reset, active low.
- clk_i  input  1  clock; all state updates on the rising edge.
- clear_i  input  1  synchronous clear of locks, error flag and FSM.
- issue_valid_i  input  1  launcher output valid.
- issue_ready_i  input  1  downstream ready; issue fires when both valid and ready are 1.
- issue_rd_i  input  $clog2(NR)  destination register of the issuing instruction.
- issue_wr_i  input  1  issuing instruction writes issue_rd_i.
- wb_valid_i  input  NWB  per-port writeback valid.
- wb_rd_i  input  NWB x $clog2(NR)  per-port retired register.
- flush_req_i  input  1  level request to drain the machine.
- issue_allow_o  output  1  permits the launcher to issue; gates its ready.
- flush_ack_o  output  1  drain complete.
- locks_o  output  NR  registered lock vector (bit i set = register i has a pending write).
- outstanding_o  output  $clog2(NR+1)  popcount of locks_o.
- err_o  output  1  sticky protocol-error flag.

## Operation
- Lock set: on an issue fire with issue_wr_i=1 and issue_rd_i!=0, set lock[issue_rd_i].
- Lock clear: for every port p with wb_valid_i[p]=1 and wb_rd_i[p]!=0, clear lock[wb_rd_i[p]]. Several ports may clear different registers in the same cycle.
- Same register set and cleared in the same cycle: the set wins, and the register stays locked for the new producer.
- Two ports clearing the same register: a single clear is applied.
- rd=0 is ignored on both paths, so lock[0] is always 0.
- FSM states are RUN, DRAIN and DONE; the state type is sb_state_e.
  - RUN: issue_allow_o=1. flush_req_i=1 moves to DRAIN.
  - DRAIN: issue_allow_o=0. When the lock register is all-zero and no issue fires this cycle, move to DONE.
  - DONE: issue_allow_o=0 and flush_ack_o=1. flush_req_i=0 moves to RUN.
- flush_req_i dropping during DRAIN returns the FSM to RUN.
- Issue fires while issue_allow_o=0 are still tracked.
- clear_i=1 has priority over every other event: locks become 0, err_o becomes 0, and the FSM goes to RUN.

## Timing
- Reset values:
  - locks_o=0, outstanding_o=0, err_o=0.
  - FSM=RUN, so issue_allow_o=1 and flush_ack_o=0.
- Issue fire in cycle n appears in locks_o in cycle n+1. A writeback in cycle n clears the lock in cycle n+1. There is no combinational bypass.
- outstanding_o is combinational from the lock register and tracks locks_o in the same cycle.
- State-derived outputs:
  - issue_allow_o and flush_ack_o decode directly from the registered state.
  - flush_req_i asserted in cycle n gives issue_allow_o=0 in cycle n+1. A fire in cycle n is still tracked.
- Minimum flush latency with no outstanding writes: request in cycle n, DRAIN in n+1, flush_ack_o=1 in cycle n+2.
- Asynchronous reset mid-drain returns the block to the reset values immediately; the drain is abandoned.

## Configuration
- RV64G_SCOREBOARD_CHECK_EN defined: err_o is set, and stays set until clear_i or reset, on any of these events:
  - a writeback to an unlocked register, unless that register is set in the same cycle;
  - an issue to a register that is already locked and not cleared in that cycle;
  - an issue fire while issue_allow_o=0.
- RV64G_SCOREBOARD_CHECK_EN undefined: err_o is tied to 0 and none of the check logic exists. Lock behaviour is identical in both builds.

## Structure
- rv64g_pkg gains NUM_WB_PORTS and the sb_state_e enum (RUN, DRAIN, DONE); NUM_REGS is reused.
- One sub-module, count_ones #(.NW(NR)): a combinational popcount producing outstanding_o.
- All other logic stays in rv64g_reg_scoreboard.

## Test plan
- After reset: issue fire with rd=5, wr=1 -> locks_o=0x20 next cycle, outstanding_o=1. wb_valid=01, wb_rd[0]=5 -> locks_o=0 the following cycle.
- Issue fire to rd=0, and writeback on rd=0 -> locks_o stays 0 and err_o stays 0.
- With lock[7] set: same-cycle issue fire rd=7 and wb rd=7 -> lock[7] remains 1 and err_o stays 0. Same-cycle wb on ports 0 and 1 to rd=3 and rd=9 (both locked) -> both cleared in one cycle.
- Locks set on rd 2, 4, 6; flush_req_i=1 at cycle 10 -> issue_allow_o=0 at 11. Retire the three registers in cycles 12-14 -> flush_ack_o=1 at cycle 16. Drop flush_req_i -> RUN and issue_allow_o=1 one cycle later.
- With RV64G_SCOREBOARD_CHECK_EN defined: wb to unlocked rd=12 -> err_o=1 next cycle and held; clear_i -> err_o=0. With the macro undefined, the same stimulus leaves err_o=0.
- Assert arst_ni low while in DRAIN with 4 locks set -> locks_o=0 and issue_allow_o=1 immediately; resume clean operation after release.
